// File: rtl/fix_query_arbiter_if.sv
// Host query ports and parser read-path signals shared by the FIX query arbiter.
interface fix_query_arbiter_if #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned TAG_WIDTH   = 32,
    parameter int unsigned NUM_MESSAGE = 10,
    parameter int unsigned VALUE_WIDTH = 256
);
    // Host side
    logic [NUM_REQ-1:0]             req_valid_i;
    logic [NUM_REQ*TAG_WIDTH-1:0]   req_tag_i;
    logic [NUM_REQ*NUM_MESSAGE-1:0] req_msg_i;
    logic [NUM_REQ-1:0]             req_ready_o;
    logic [NUM_REQ-1:0]             rsp_valid_o;
    logic                           rsp_hit_o;
    logic [VALUE_WIDTH-1:0]         rsp_value_o;
    logic                           busy_o;

    // Parser side
    logic [TAG_WIDTH-1:0]           find_tag_o;
    logic [NUM_MESSAGE-1:0]         message_num_o;
    logic                           read_message_o;
    logic [VALUE_WIDTH-1:0]         value_i;
    logic                           value_valid_i;
    logic                           empty_i;

    // Environment view: drives requests and parser results
    modport master (
        output req_valid_i, req_tag_i, req_msg_i, value_i, value_valid_i, empty_i,
        input  req_ready_o, rsp_valid_o, rsp_hit_o, rsp_value_o, busy_o,
               find_tag_o, message_num_o, read_message_o
    );

    // Arbiter view
    modport slave (
        input  req_valid_i, req_tag_i, req_msg_i, value_i, value_valid_i, empty_i,
        output req_ready_o, rsp_valid_o, rsp_hit_o, rsp_value_o, busy_o,
               find_tag_o, message_num_o, read_message_o
    );
endinterface

// File: rtl/fix_query_arbiter.sv
// Round-robin arbiter sharing the FIX parser tag-search / value read path among host query ports.
module fix_query_arbiter #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned TAG_WIDTH   = 32,
    parameter int unsigned NUM_MESSAGE = 10,
    parameter int unsigned VALUE_WIDTH = 256,
    parameter int unsigned TIMEOUT     = 15
) (
    input  logic              clk,
    input  logic              rst,
    fix_query_arbiter_if.slave bus
);
    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [IDX_W-1:0]        ptr_q;
    logic [IDX_W-1:0]        owner_q;
    logic [IDX_W-1:0]        winner_c;
    logic [IDX_W-1:0]        ptr_next_c;
    logic                    any_req_c;
    logic                    timeout_c;
    logic [CNT_W-1:0]        cnt_q;
    logic [TAG_WIDTH-1:0]    tag_q;
    logic [NUM_MESSAGE-1:0]  msg_q;
    logic                    hit_q;
    logic [VALUE_WIDTH-1:0]  value_q;

    // First pending requester at or after the pointer, scanning upward with wrap
    always_comb begin
        logic [IDX_W-1:0] idx;
        idx       = '0;
        winner_c  = '0;
        any_req_c = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = IDX_W'((32'(ptr_q) + i) % NUM_REQ);
            if (!any_req_c && bus.req_valid_i[idx]) begin
                any_req_c = 1'b1;
                winner_c  = idx;
            end
        end
    end

    assign ptr_next_c = IDX_W'((32'(winner_c) + 32'd1) % NUM_REQ);
    assign timeout_c  = (cnt_q == CNT_W'(TIMEOUT - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and state-decoded strobes
    always_comb begin
        state_d            = state_q;
        bus.req_ready_o    = '0;
        bus.read_message_o = 1'b0;
        bus.rsp_valid_o    = '0;
        bus.busy_o         = (state_q != S_IDLE);
        case (state_q)
            S_IDLE: begin
                if (any_req_c) begin
                    bus.req_ready_o[winner_c] = 1'b1;
                    state_d = bus.empty_i ? S_RESP : S_ISSUE;
                end
            end
            S_ISSUE: begin
                bus.read_message_o = 1'b1;
                state_d            = S_WAIT;
            end
            S_WAIT: begin
                if (bus.value_valid_i || timeout_c) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                bus.rsp_valid_o[owner_q] = 1'b1;
                state_d                  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Query capture, pointer advance, wait counter and response latch
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q   <= '0;
            owner_q <= '0;
            cnt_q   <= '0;
            tag_q   <= '0;
            msg_q   <= '0;
            hit_q   <= 1'b0;
            value_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (any_req_c) begin
                        ptr_q   <= ptr_next_c;
                        owner_q <= winner_c;
                        tag_q   <= bus.req_tag_i[32'(winner_c) * TAG_WIDTH +: TAG_WIDTH];
                        msg_q   <= bus.req_msg_i[32'(winner_c) * NUM_MESSAGE +: NUM_MESSAGE];
                        if (bus.empty_i) begin
                            hit_q   <= 1'b0;
                            value_q <= '0;
                        end
                    end
                end
                S_ISSUE: begin
                    cnt_q <= '0;
                end
                S_WAIT: begin
                    // A valid arriving on the timeout cycle still counts as a hit
                    if (bus.value_valid_i) begin
                        hit_q   <= 1'b1;
                        value_q <= bus.value_i;
                    end else if (timeout_c) begin
                        hit_q   <= 1'b0;
                        value_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.find_tag_o    = tag_q;
    assign bus.message_num_o = msg_q;
    assign bus.rsp_hit_o     = hit_q;
    assign bus.rsp_value_o   = value_q;
endmodule

// File: tb/tb_fix_query_arbiter.sv
// Directed self-checking bench for fix_query_arbiter.
module tb_fix_query_arbiter;
    localparam int unsigned NR = 4;
    localparam int unsigned TW = 32;
    localparam int unsigned MW = 10;
    localparam int unsigned VW = 256;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    logic [TW-1:0] exp_tag [NR];
    logic [MW-1:0] exp_msg [NR];

    fix_query_arbiter_if #(
        .NUM_REQ(NR), .TAG_WIDTH(TW), .NUM_MESSAGE(MW), .VALUE_WIDTH(VW)
    ) bus ();

    fix_query_arbiter #(
        .NUM_REQ(NR), .TAG_WIDTH(TW), .NUM_MESSAGE(MW), .VALUE_WIDTH(VW), .TIMEOUT(15)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the run can never hang
    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full hit transaction; caller is in IDLE with the requester's valid already driven
    task automatic run_hit(input int port, input bit drop, input logic [VW-1:0] val);
        logic [NR-1:0] oh;
        oh = NR'(1 << port);
        #1;
        chk("grant", VW'(bus.req_ready_o), VW'(oh));
        chk("idle_busy", VW'(bus.busy_o), '0);
        tick();
        if (drop) bus.req_valid_i[2'(port)] = 1'b0;
        #1;
        chk("issue_read", VW'(bus.read_message_o), VW'(1));
        chk("issue_tag", VW'(bus.find_tag_o), VW'(exp_tag[port]));
        chk("issue_msg", VW'(bus.message_num_o), VW'(exp_msg[port]));
        chk("issue_ready", VW'(bus.req_ready_o), '0);
        tick();
        chk("wait_read", VW'(bus.read_message_o), '0);
        chk("wait_tag", VW'(bus.find_tag_o), VW'(exp_tag[port]));
        bus.value_valid_i = 1'b1;
        bus.value_i       = val;
        tick();
        bus.value_valid_i = 1'b0;
        chk("rsp_valid", VW'(bus.rsp_valid_o), VW'(oh));
        chk("rsp_hit", VW'(bus.rsp_hit_o), VW'(1));
        chk("rsp_value", bus.rsp_value_o, val);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        exp_tag[0] = 32'd100; exp_msg[0] = 10'd1;
        exp_tag[1] = 32'd35;  exp_msg[1] = 10'd3;
        exp_tag[2] = 32'd102; exp_msg[2] = 10'd5;
        exp_tag[3] = 32'd103; exp_msg[3] = 10'd7;
        rst               = 1'b1;
        bus.req_valid_i   = '0;
        bus.req_tag_i     = '0;
        bus.req_msg_i     = '0;
        bus.value_i       = '0;
        bus.value_valid_i = 1'b0;
        bus.empty_i       = 1'b0;
        for (int r = 0; r < int'(NR); r++) begin
            bus.req_tag_i[r*TW +: TW] = exp_tag[r];
            bus.req_msg_i[r*MW +: MW] = exp_msg[r];
        end
        tick();
        tick();
        chk("rst_busy", VW'(bus.busy_o), '0);
        chk("rst_rsp_valid", VW'(bus.rsp_valid_o), '0);
        chk("rst_read", VW'(bus.read_message_o), '0);
        chk("rst_tag", VW'(bus.find_tag_o), '0);
        chk("rst_value", bus.rsp_value_o, '0);
        rst = 1'b0;

        // Single hit on port 1
        bus.req_valid_i = 4'b0010;
        run_hit(1, 1'b1, VW'(32'hABCD));
        tick();
        chk("post_hit_rsp_valid", VW'(bus.rsp_valid_o), '0);
        chk("post_hit_busy", VW'(bus.busy_o), '0);
        chk("post_hit_hold_value", bus.rsp_value_o, VW'(32'hABCD));

        // Reset while a query is in WAIT
        bus.req_valid_i = 4'b0001;
        #1;
        chk("mid_grant", VW'(bus.req_ready_o), VW'(4'b0001));
        tick();
        bus.req_valid_i = '0;
        tick();
        chk("mid_wait_busy", VW'(bus.busy_o), VW'(1));
        rst = 1'b1;
        tick();
        chk("mid_rst_busy", VW'(bus.busy_o), '0);
        chk("mid_rst_rsp_valid", VW'(bus.rsp_valid_o), '0);
        chk("mid_rst_read", VW'(bus.read_message_o), '0);
        chk("mid_rst_tag", VW'(bus.find_tag_o), '0);
        chk("mid_rst_msg", VW'(bus.message_num_o), '0);
        chk("mid_rst_hit", VW'(bus.rsp_hit_o), '0);
        chk("mid_rst_value", bus.rsp_value_o, '0);
        rst = 1'b0;

        // Round robin with every port continuously valid; pointer restarts at 0
        bus.req_valid_i = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            run_hit(k % 4, 1'b0, VW'(32'h50 + k));
            if (k == 4) bus.req_valid_i = '0;
            tick();
        end
        chk("rr_end_busy", VW'(bus.busy_o), '0);

        // Timeout on port 2 (pointer now 1)
        bus.req_valid_i = 4'b0100;
        #1;
        chk("to_grant", VW'(bus.req_ready_o), VW'(4'b0100));
        tick();
        bus.req_valid_i = '0;
        chk("to_read", VW'(bus.read_message_o), VW'(1));
        chk("to_tag", VW'(bus.find_tag_o), VW'(exp_tag[2]));
        for (int c = 2; c <= 16; c++) begin
            tick();
            chk("to_no_rsp", VW'(bus.rsp_valid_o), '0);
            chk("to_no_read", VW'(bus.read_message_o), '0);
        end
        tick();
        chk("to_rsp_valid", VW'(bus.rsp_valid_o), VW'(4'b0100));
        chk("to_hit", VW'(bus.rsp_hit_o), '0);
        chk("to_value", bus.rsp_value_o, '0);
        tick();

        // Empty store on port 3 (pointer now 3)
        bus.empty_i     = 1'b1;
        bus.req_valid_i = 4'b1000;
        #1;
        chk("emp_grant", VW'(bus.req_ready_o), VW'(4'b1000));
        tick();
        bus.req_valid_i = '0;
        chk("emp_rsp_valid", VW'(bus.rsp_valid_o), VW'(4'b1000));
        chk("emp_hit", VW'(bus.rsp_hit_o), '0);
        chk("emp_read", VW'(bus.read_message_o), '0);
        tick();
        bus.empty_i = 1'b0;
        chk("emp_idle_busy", VW'(bus.busy_o), '0);
        chk("emp_idle_read", VW'(bus.read_message_o), '0);

        // Valid arriving exactly on the last wait cycle (pointer now 0, only port 1 asks)
        bus.req_valid_i = 4'b0010;
        #1;
        chk("vt_grant", VW'(bus.req_ready_o), VW'(4'b0010));
        tick();
        bus.req_valid_i = '0;
        chk("vt_read", VW'(bus.read_message_o), VW'(1));
        tick();
        for (int c = 0; c < 14; c++) begin
            tick();
            chk("vt_no_rsp", VW'(bus.rsp_valid_o), '0);
        end
        bus.value_valid_i = 1'b1;
        bus.value_i       = VW'(32'h1234_5678);
        tick();
        bus.value_valid_i = 1'b0;
        chk("vt_rsp_valid", VW'(bus.rsp_valid_o), VW'(4'b0010));
        chk("vt_hit", VW'(bus.rsp_hit_o), VW'(1));
        chk("vt_value", bus.rsp_value_o, VW'(32'h1234_5678));
        tick();

        // Stray valid while idle
        bus.value_valid_i = 1'b1;
        bus.value_i       = VW'(32'hFFFF);
        for (int c = 0; c < 2; c++) begin
            tick();
            chk("stray_rsp_valid", VW'(bus.rsp_valid_o), '0);
            chk("stray_busy", VW'(bus.busy_o), '0);
            chk("stray_hold_value", bus.rsp_value_o, VW'(32'h1234_5678));
            chk("stray_hold_hit", VW'(bus.rsp_hit_o), VW'(1));
        end
        bus.value_valid_i = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
